// File: rtl/packer_sched.sv
// Message-level round-robin scheduler sharing one 64-bit packer among N_REQ encoder lanes.
// A lane owns the packer for a whole message; the flush handshake closes it before the next grant.
module packer_sched #(
    parameter int N_REQ         = 4,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [64*N_REQ-1:0]   req_data,
    input  logic [7*N_REQ-1:0]    req_bits,
    input  logic [N_REQ-1:0]      req_last,
    output logic [N_REQ-1:0]      req_ready,
    output logic [63:0]           pk_data_in,
    output logic [6:0]            pk_valid_bits,
    output logic                  pk_data_valid,
    output logic                  pk_msg_fin,
    input  logic                  pk_done,
    output logic                  grant_valid,
    output logic [2:0]            grant_id,
    output logic [15:0]           msg_count,
    output logic                  err_bits,
    output logic                  err_timeout
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GRANT     = 2'd1;
    localparam logic [1:0] FIN       = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]  state;
    logic [2:0]  rr_ptr;
    logic [7:0]  cnt;

    logic        any_lo, any_hi;
    logic [2:0]  win_lo, win_hi, winner;
    logic        sel_valid, sel_last, bits_legal;
    logic [63:0] sel_data, masked;
    logic [6:0]  sel_bits;
    logic [2:0]  next_ptr;

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        any_lo = 1'b0;
        any_hi = 1'b0;
        win_lo = '0;
        win_hi = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !any_lo) begin
                any_lo = 1'b1;
                win_lo = 3'(i);
            end
            if (req_valid[i] && (3'(i) >= rr_ptr) && !any_hi) begin
                any_hi = 1'b1;
                win_hi = 3'(i);
            end
        end
        winner = any_hi ? win_hi : win_lo;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_bits  = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_data     = req_data[64*i +: 64];
                sel_bits     = req_bits[7*i +: 7];
                req_ready[i] = (state == GRANT);
            end
        end
        bits_legal = (sel_bits != 7'd0) && (sel_bits <= 7'd64);
        masked     = (sel_bits >= 7'd64) ? sel_data
                                         : (sel_data & ((64'd1 << sel_bits) - 64'd1));
        next_ptr   = (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            pk_data_in    <= '0;
            pk_valid_bits <= '0;
            pk_data_valid <= 1'b0;
            pk_msg_fin    <= 1'b0;
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            msg_count     <= '0;
            err_bits      <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            pk_data_valid <= 1'b0;
            pk_msg_fin    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_lo) begin
                        grant_valid <= 1'b1;
                        grant_id    <= winner;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (sel_valid) begin
                        if (bits_legal) begin
                            pk_data_valid <= 1'b1;
                            pk_data_in    <= masked;
                            pk_valid_bits <= sel_bits;
                        end else begin
                            err_bits <= 1'b1;
                        end
                        if (sel_last) state <= FIN;
                    end
                end
                FIN: begin
                    pk_msg_fin <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // pk_done on the expiry cycle still counts as a clean completion.
                    if (pk_done || (cnt == 8'(FLUSH_TIMEOUT - 1))) begin
                        if (pk_done) msg_count   <= msg_count + 16'd1;
                        else         err_timeout <= 1'b1;
                        grant_valid <= 1'b0;
                        rr_ptr      <= next_ptr;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packer_sched.sv
// Directed-vector bench for packer_sched: grant timing, masking, round-robin, errors, timeout, reset.
module tb_packer_sched;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [255:0]  req_data;
    logic [27:0]   req_bits;
    logic [3:0]    req_last;
    logic [3:0]    req_ready;
    logic [63:0]   pk_data_in;
    logic [6:0]    pk_valid_bits;
    logic          pk_data_valid;
    logic          pk_msg_fin;
    logic          pk_done;
    logic          grant_valid;
    logic [2:0]    grant_id;
    logic [15:0]   msg_count;
    logic          err_bits;
    logic          err_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    packer_sched #(.N_REQ(4), .FLUSH_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_bits(req_bits), .req_last(req_last),
        .req_ready(req_ready),
        .pk_data_in(pk_data_in), .pk_valid_bits(pk_valid_bits), .pk_data_valid(pk_data_valid),
        .pk_msg_fin(pk_msg_fin), .pk_done(pk_done),
        .grant_valid(grant_valid), .grant_id(grant_id), .msg_count(msg_count),
        .err_bits(err_bits), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " req_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, " pk_data_in"}, pk_data_in, 64'd0);
        check_eq({tag, " pk_valid_bits"}, 64'(pk_valid_bits), 64'd0);
        check_eq({tag, " pk_data_valid"}, 64'(pk_data_valid), 64'd0);
        check_eq({tag, " pk_msg_fin"}, 64'(pk_msg_fin), 64'd0);
        check_eq({tag, " grant_valid"}, 64'(grant_valid), 64'd0);
        check_eq({tag, " grant_id"}, 64'(grant_id), 64'd0);
        check_eq({tag, " msg_count"}, 64'(msg_count), 64'd0);
        check_eq({tag, " err_bits"}, 64'(err_bits), 64'd0);
        check_eq({tag, " err_timeout"}, 64'(err_timeout), 64'd0);
    endtask

    task automatic set_lane(input int lane, input logic [63:0] data, input logic [6:0] bits,
                            input logic last);
        req_data[64*lane +: 64] = data;
        req_bits[7*lane +: 7]   = bits;
        req_last[lane]          = last;
    endtask

    // Single-word message on one lane, pk_done given in the fin cycle.
    task automatic run_one(input int lane, input logic [63:0] data, input logic [6:0] bits,
                           input logic [63:0] exp_data);
        req_valid       = '0;
        req_valid[lane] = 1'b1;
        set_lane(lane, data, bits, 1'b1);
        step();
        check_eq("one grant_valid", 64'(grant_valid), 64'd1);
        check_eq("one grant_id", 64'(grant_id), 64'(lane));
        check_eq("one req_ready", 64'(req_ready), 64'(4'b0001 << lane));
        step();
        check_eq("one pk_data_valid", 64'(pk_data_valid), 64'd1);
        check_eq("one pk_data_in", pk_data_in, exp_data);
        check_eq("one pk_valid_bits", 64'(pk_valid_bits), 64'(bits));
        req_valid = '0;
        step();
        check_eq("one pk_msg_fin", 64'(pk_msg_fin), 64'd1);
        pk_done = 1'b1;
        step();
        check_eq("one grant released", 64'(grant_valid), 64'd0);
        pk_done = 1'b0;
    endtask

    initial begin
        logic [2:0] rr_order [5];
        rr_order = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd2};

        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_bits = '0; req_last = '0; pk_done = 1'b0;
        repeat (3) step();
        check_reset_vals("por");
        rst_n = 1'b1;
        step();

        // Three-word message on lane 0: bits 10, 64, 5.
        req_valid = 4'b0001;
        set_lane(0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd10, 1'b0);
        step();
        check_eq("t1 grant_valid", 64'(grant_valid), 64'd1);
        check_eq("t1 grant_id", 64'(grant_id), 64'd0);
        check_eq("t1 req_ready", 64'(req_ready), 64'b0001);
        check_eq("t1 no early data", 64'(pk_data_valid), 64'd0);
        step();
        check_eq("t1 w0 valid", 64'(pk_data_valid), 64'd1);
        check_eq("t1 w0 bits", 64'(pk_valid_bits), 64'd10);
        check_eq("t1 w0 data", pk_data_in, 64'h0000_0000_0000_03FF);
        set_lane(0, 64'h0123_4567_89AB_CDEF, 7'd64, 1'b0);
        step();
        check_eq("t1 w1 valid", 64'(pk_data_valid), 64'd1);
        check_eq("t1 w1 bits", 64'(pk_valid_bits), 64'd64);
        check_eq("t1 w1 data", pk_data_in, 64'h0123_4567_89AB_CDEF);
        set_lane(0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd5, 1'b1);
        step();
        check_eq("t1 w2 valid", 64'(pk_data_valid), 64'd1);
        check_eq("t1 w2 bits", 64'(pk_valid_bits), 64'd5);
        check_eq("t1 w2 data", pk_data_in, 64'h0000_0000_0000_001F);
        check_eq("t1 fin not yet", 64'(pk_msg_fin), 64'd0);
        req_valid = '0;
        step();
        check_eq("t1 data done", 64'(pk_data_valid), 64'd0);
        check_eq("t1 msg_fin", 64'(pk_msg_fin), 64'd1);
        pk_done = 1'b1;
        step();
        pk_done = 1'b0;
        check_eq("t1 fin one cycle", 64'(pk_msg_fin), 64'd0);
        check_eq("t1 grant released", 64'(grant_valid), 64'd0);
        check_eq("t1 msg_count", 64'(msg_count), 64'd1);

        // Masking on lane 1 (rr_ptr now 1).
        run_one(1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd12, 64'h0000_0000_0000_0FFF);
        check_eq("t2 msg_count", 64'(msg_count), 64'd2);

        // Round-robin with all lanes requesting; rr_ptr starts at 2.
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_lane(i, 64'hA5A5_A5A5_A5A5_A5A0 + 64'(i), 7'd8, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("rr grant_id", 64'(grant_id), 64'(rr_order[k]));
            check_eq("rr req_ready", 64'(req_ready), 64'(4'b0001 << rr_order[k]));
            step();
            check_eq("rr data", pk_data_in, 64'hA0 + 64'(rr_order[k]));
            step();
            check_eq("rr fin", 64'(pk_msg_fin), 64'd1);
            check_eq("rr ready idle", 64'(req_ready), 64'd0);
            step();
            pk_done = 1'b1;
            step();
            pk_done = 1'b0;
            check_eq("rr released", 64'(grant_valid), 64'd0);
            if (k == 4) req_valid = '0;
        end
        check_eq("rr msg_count", 64'(msg_count), 64'd7);

        // Illegal bit counts on lane 3 mid-message.
        check_eq("t4 err_bits clear", 64'(err_bits), 64'd0);
        req_valid = 4'b1000;
        set_lane(3, 64'h0000_0000_0000_00FF, 7'd7, 1'b0);
        step();
        check_eq("t4 grant_id", 64'(grant_id), 64'd3);
        step();
        check_eq("t4 w0 bits", 64'(pk_valid_bits), 64'd7);
        check_eq("t4 w0 data", pk_data_in, 64'h7F);
        set_lane(3, 64'h1234, 7'd0, 1'b0);
        step();
        check_eq("t4 bits0 dropped", 64'(pk_data_valid), 64'd0);
        check_eq("t4 err_bits", 64'(err_bits), 64'd1);
        set_lane(3, 64'h5678, 7'd65, 1'b0);
        step();
        check_eq("t4 bits65 dropped", 64'(pk_data_valid), 64'd0);
        set_lane(3, 64'hCAFE_BABE_DEAD_BEEF, 7'd64, 1'b1);
        step();
        check_eq("t4 last valid", 64'(pk_data_valid), 64'd1);
        check_eq("t4 last data", pk_data_in, 64'hCAFE_BABE_DEAD_BEEF);
        req_valid = '0;
        step();
        check_eq("t4 fin", 64'(pk_msg_fin), 64'd1);
        pk_done = 1'b1;
        step();
        pk_done = 1'b0;
        check_eq("t4 msg_count", 64'(msg_count), 64'd8);

        // pk_done arriving on the 8th WAIT_DONE cycle: no error (lane 0).
        req_valid = 4'b0001;
        set_lane(0, 64'h1, 7'd1, 1'b1);
        step();
        step();
        req_valid = '0;
        step();
        check_eq("t5a fin", 64'(pk_msg_fin), 64'd1);
        repeat (7) step();
        check_eq("t5a still granted", 64'(grant_valid), 64'd1);
        pk_done = 1'b1;
        step();
        pk_done = 1'b0;
        check_eq("t5a released", 64'(grant_valid), 64'd0);
        check_eq("t5a no timeout", 64'(err_timeout), 64'd0);
        check_eq("t5a msg_count", 64'(msg_count), 64'd9);

        // pk_done never arrives: timeout after 8 WAIT_DONE cycles (lane 1).
        req_valid = 4'b0010;
        set_lane(1, 64'h3, 7'd2, 1'b1);
        step();
        check_eq("t5b grant_id", 64'(grant_id), 64'd1);
        step();
        req_valid = '0;
        step();
        repeat (7) step();
        check_eq("t5b waiting", 64'(grant_valid), 64'd1);
        check_eq("t5b not yet", 64'(err_timeout), 64'd0);
        step();
        check_eq("t5b released", 64'(grant_valid), 64'd0);
        check_eq("t5b err_timeout", 64'(err_timeout), 64'd1);
        check_eq("t5b msg_count", 64'(msg_count), 64'd9);

        pk_done = 1'b1;
        step();
        pk_done = 1'b0;
        check_eq("stray pk_done", 64'(msg_count), 64'd9);

        run_one(2, 64'hFFFF, 7'd4, 64'hF);
        check_eq("t5c msg_count", 64'(msg_count), 64'd10);

        // Reset in the middle of a lane-3 message (rr_ptr is 3 before reset).
        req_valid = 4'b1000;
        set_lane(3, 64'hFF, 7'd8, 1'b0);
        step();
        check_eq("t6 grant_id", 64'(grant_id), 64'd3);
        step();
        check_eq("t6 mid data", 64'(pk_data_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid");
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();
        req_valid = 4'b1100;
        set_lane(2, 64'h1, 7'd1, 1'b1);
        step();
        check_eq("t6 post-reset grant", 64'(grant_id), 64'd2);
        check_eq("t6 post-reset valid", 64'(grant_valid), 64'd1);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/packer_sched.md
# packer_sched

Message-level scheduler that shares the single 64-bit shift-concatenation packer among N_REQ encoder lanes. It grants one lane at a time for a whole message and forwards that lane's variable-length codewords (1–64 bits) to the packer with upper bits masked. At message end it sequences the packer flush (msg_fin) and waits for the packer's done before granting again. Lanes are served round-robin. Sits between the compression/encryption encoder lanes and the packer.

## Interface
- N_REQ, 4, number of requester lanes (2..8)
- FLUSH_TIMEOUT, 255, max cycles to wait for pk_done after msg_fin (1..255)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  lane i has a codeword on its slice
- req_data  in  64*N_REQ  lane i codeword at bits [64i+63:64i], LSB-aligned
- req_bits  in  7*N_REQ  lane i valid bit count, legal 1..64
- req_last  in  N_REQ  lane i codeword is the last of its message
- req_ready  out  N_REQ  lane i codeword consumed this cycle (combinational)
- pk_data_in  out  64  codeword to packer, bits at and above pk_valid_bits forced to 0
- pk_valid_bits  out  7  bit count to packer
- pk_data_valid  out  1  pk_data_in/pk_valid_bits valid this cycle
- pk_msg_fin  out  1  one-cycle flush request to packer
- pk_done  in  1  packer finished flushing the message
- grant_valid  out  1  a lane currently owns the packer
- grant_id  out  3  owning lane index
- msg_count  out  16  completed messages, wraps at 65535→0
- err_bits  out  1  sticky: illegal req_bits seen
- err_timeout  out  1  sticky: pk_done not seen within FLUSH_TIMEOUT

## Operation
- States: IDLE, GRANT, FIN, WAIT_DONE. Reset state IDLE.
- IDLE: if any req_valid, winner = first set index at or after rr_ptr (wrapping); next cycle GRANT with grant_id = winner, grant_valid = 1. No req_valid → stay.
- GRANT: req_ready[grant_id] = 1, all other req_ready = 0. Each handshake (valid & ready) with legal req_bits forwards codeword next cycle. req_valid low → no-op cycle, grant held. Handshake with req_last → FIN.
- Illegal req_bits (0 or >64): word consumed, not forwarded, err_bits set. If also req_last, message still closes normally.
- Masking: pk_data_in = req_data slice AND (2^req_bits − 1); 64 passes all bits.
- FIN: one cycle; drives pk_msg_fin for next cycle; → WAIT_DONE.
- WAIT_DONE: timeout counter counts up from 0. pk_done → IDLE, msg_count += 1, rr_ptr = (grant_id + 1) mod N_REQ, grant_valid = 0. Counter reaching FLUSH_TIMEOUT without pk_done → err_timeout set, same exit but msg_count unchanged. pk_done on the expiry cycle → treated as done, no error.
- pk_done outside WAIT_DONE ignored.
- Other lanes' requests ignored while not in IDLE; their req_ready stays 0.
- Errors clear only on reset.

## Timing
- Reset values: req_ready 0, pk_data_in 0, pk_valid_bits 0, pk_data_valid 0, pk_msg_fin 0, grant_valid 0, grant_id 0, msg_count 0, err_bits 0, err_timeout 0; rr_ptr 0; counter 0.
- pk_* outputs, grant_*, msg_count, err_* are registered. req_ready is combinational from state/grant_id only (not from req_valid).
- Request at IDLE cycle t → grant_valid/grant_id at t+1, first handshake possible at t+1.
- Handshake at cycle t → pk_data_valid = 1 at t+1 exactly one cycle; back-to-back handshakes give back-to-back pk_data_valid.
- Last handshake at t → last pk_data_valid at t+1, pk_msg_fin = 1 at t+2 only, WAIT_DONE from t+2, pk_done sampled from t+2.
- pk_done at cycle d → grant_valid = 0 and msg_count updated at d+1; next grant earliest d+2.
- Reset asserted mid-message: all outputs to reset values immediately; partial message abandoned.

## Test plan
- Single lane 0: three words (bits 10, 64, 5; last on third) → pk_data_valid three consecutive cycles with pk_valid_bits 10,64,5, pk_msg_fin 2 cycles after last handshake; pk_done → msg_count = 1.
- Masking: req_data = all ones, req_bits = 12 → pk_data_in = 0x0000_0000_0000_0FFF.
- Round-robin: lanes 0..3 all request continuously, 1-word messages, pk_done 1 cycle after fin → grant order 0,1,2,3,0; no req_ready to non-granted lanes.
- Illegal bits: req_bits = 0 then 65 mid-message → both consumed, no pk_data_valid for them, err_bits = 1, message still completes.
- Timeout: FLUSH_TIMEOUT = 8, pk_done held low → err_timeout = 1 after 8 WAIT_DONE cycles, back to IDLE, msg_count unchanged; pk_done on 8th cycle instead → no error.
- Reset mid-message: rst_n low during GRANT → all outputs zero asynchronously; after release first request from lane 2 granted (rr_ptr 0 search).
